hid_key_decoder: RTL and testbench

//  Accepts 8-byte USB HID boot-keyboard reports as a byte stream from the USB host bridge.

---
 rtl/hid_key_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_hid_key_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hid_key_decoder
//  Description : Turns a byte stream of 8-byte USB HID boot-keyboard reports
//                into one movement keycode for the player, a fire flag for the
//                missile logic, and a one-cycle strobe per good report.
//                A rollover report or an inter-byte timeout raises err_stb.
//  Ports       : Clk        in   system clock
//                Reset_n    in   asynchronous reset, active low
//                rx_data    in   [7:0] report byte
//                rx_valid   in   rx_data valid this cycle
//                rx_ready   out  decoder accepts a byte (transfer = valid&ready)
//                keycode    out  [7:0] 00 none, 04 left, 07 right
//                fire       out  FIRE_CODE present in the last good report
//                report_stb out  one-cycle pulse when keycode/fire update
//                err_stb    out  one-cycle pulse on timeout or rollover report
//  Revision    : 1.0  initial release
// ============================================================================
module hid_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  FIRE_CODE      = 8'h2C
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] keycode,
    output logic       fire,
    output logic       report_stb,
    output logic       err_stb
);

    // Timeout counter only has to hold TIMEOUT_CYCLES-1.
    localparam int unsigned c_TCNT_W =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TCNT_W-1:0] c_TCNT_MAX = c_TCNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_KEY_NONE  = 8'h00;
    localparam logic [7:0] c_KEY_LEFT  = 8'h04;
    localparam logic [7:0] c_KEY_RIGHT = 8'h07;
    localparam logic [7:0] c_ARROW_L   = 8'h50;
    localparam logic [7:0] c_ARROW_R   = 8'h4F;
    localparam logic [7:0] c_ROLLOVER  = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [c_TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]          slot_q [6];
    logic [7:0]          slot_d [6];
    logic [7:0]          keycode_q, keycode_d;
    logic                fire_q, fire_d;
    logic                report_stb_q, report_stb_d;
    logic                err_stb_q, err_stb_d;
    logic                rx_ready_q, rx_ready_d;

    logic                w_accept;
    logic [5:0]          w_left;
    logic [5:0]          w_right;
    logic [5:0]          w_fire;
    logic [5:0]          w_roll;
    logic                w_any_left;
    logic                w_any_right;
    logic                w_rollover;

    assign w_accept = rx_valid & rx_ready_q;

    // Per-slot usage matches, reduced below into report-wide flags.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_slot
            assign w_left[gi]  = (slot_q[gi] == c_KEY_LEFT)  || (slot_q[gi] == c_ARROW_L);
            assign w_right[gi] = (slot_q[gi] == c_KEY_RIGHT) || (slot_q[gi] == c_ARROW_R);
            assign w_fire[gi]  = (slot_q[gi] == FIRE_CODE);
            assign w_roll[gi]  = (slot_q[gi] == c_ROLLOVER);
        end
    endgenerate

    assign w_any_left  = |w_left;
    assign w_any_right = |w_right;
    // Phantom-state report: the keyboard could not resolve the pressed keys.
    assign w_rollover  = &w_roll;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        keycode_d    = keycode_q;
        fire_d       = fire_q;
        report_stb_d = 1'b0;
        err_stb_d    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slot_d[i] = slot_q[i];
        end

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                // First byte is the modifier; it carries nothing we decode.
                if (w_accept) begin
                    cnt_d   = 3'd1;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (w_accept) begin
                    tcnt_d = '0;
                    cnt_d  = cnt_q + 3'd1;
                    // Byte 1 is reserved; bytes 2..7 land in slot 0..5.
                    for (int i = 0; i < 6; i++) begin
                        if (cnt_q == 3'(i + 2)) begin
                            slot_d[i] = rx_data;
                        end
                    end
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = S_EVAL;
                    end
                end else if (tcnt_q == c_TCNT_MAX) begin
                    // Host stalled mid-report: drop the partial report so the
                    // next byte is taken as a fresh modifier.
                    err_stb_d = 1'b1;
                    cnt_d     = 3'd0;
                    tcnt_d    = '0;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + c_TCNT_W'(1);
                end
            end

            S_EVAL: begin
                state_d = S_IDLE;
                if (w_rollover) begin
                    // Keep the last good keycode/fire; only flag the error.
                    err_stb_d = 1'b1;
                end else begin
                    if (w_any_left && !w_any_right) begin
                        keycode_d = c_KEY_LEFT;
                    end else if (w_any_right && !w_any_left) begin
                        keycode_d = c_KEY_RIGHT;
                    end else begin
                        keycode_d = c_KEY_NONE;
                    end
                    fire_d       = |w_fire;
                    report_stb_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                tcnt_d  = '0;
            end
        endcase

        // Registered ready: low exactly while the next state is EVAL, and low
        // throughout reset because it comes out of a reset flop.
        rx_ready_d = (state_d != S_EVAL);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            tcnt_q       <= '0;
            keycode_q    <= c_KEY_NONE;
            fire_q       <= 1'b0;
            report_stb_q <= 1'b0;
            err_stb_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            keycode_q    <= keycode_d;
            fire_q       <= fire_d;
            report_stb_q <= report_stb_d;
            err_stb_q    <= err_stb_d;
            rx_ready_q   <= rx_ready_d;
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign rx_ready   = rx_ready_q;
    assign keycode    = keycode_q;
    assign fire       = fire_q;
    assign report_stb = report_stb_q;
    assign err_stb    = err_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_hid_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hid_key_decoder
//  Description : Self-checking bench for hid_key_decoder. A report-level model
//                (byte queue + decode rules) predicts every output each cycle;
//                directed literal checks pin the model on key scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hid_key_decoder;

    localparam int T = 16;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] keycode;
    logic       fire;
    logic       report_stb;
    logic       err_stb;

    int checks = 0;
    int errors = 0;

    hid_key_decoder #(
        .TIMEOUT_CYCLES(T),
        .FIRE_CODE     (8'h2C)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .keycode   (keycode),
        .fire      (fire),
        .report_stb(report_stb),
        .err_stb   (err_stb)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- report-level model ----------------
    logic [7:0] rep [$];
    logic [7:0] m_key;
    logic       m_fire, m_stb, m_err, m_ready, m_eval;
    int         m_idle;
    logic       d_l, d_r, d_f;
    int         d_ones;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rep.delete();
            m_key = 8'h00; m_fire = 1'b0; m_stb = 1'b0; m_err = 1'b0;
            m_ready = 1'b0; m_eval = 1'b0; m_idle = 0;
        end else begin
            m_stb = 1'b0;
            m_err = 1'b0;
            if (m_eval) begin
                d_l = 1'b0; d_r = 1'b0; d_f = 1'b0; d_ones = 0;
                for (int i = 2; i < 8; i++) begin
                    if (rep[i] == 8'h04 || rep[i] == 8'h50) d_l = 1'b1;
                    if (rep[i] == 8'h07 || rep[i] == 8'h4F) d_r = 1'b1;
                    if (rep[i] == 8'h2C) d_f = 1'b1;
                    if (rep[i] == 8'h01) d_ones++;
                end
                if (d_ones == 6) begin
                    m_err = 1'b1;
                end else begin
                    m_key  = (d_l && !d_r) ? 8'h04 : ((d_r && !d_l) ? 8'h07 : 8'h00);
                    m_fire = d_f;
                    m_stb  = 1'b1;
                end
                rep.delete();
                m_eval  = 1'b0;
                m_ready = 1'b1;
            end else if (rx_valid && m_ready) begin
                rep.push_back(rx_data);
                m_idle = 0;
                if (rep.size() == 8) begin
                    m_eval  = 1'b1;
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
                if (rep.size() > 0) begin
                    m_idle++;
                    if (m_idle == T) begin
                        m_err = 1'b1;
                        rep.delete();
                        m_idle = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("cmp_keycode",    keycode,    m_key);
            chk("cmp_fire",       fire,       m_fire);
            chk("cmp_report_stb", report_stb, m_stb);
            chk("cmp_err_stb",    err_stb,    m_err);
            chk("cmp_rx_ready",   rx_ready,   m_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] pkt [8];

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (1) begin
            @(negedge Clk);
            if (rx_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_byte: got rx_ready 0 for 50 cycles required 1");
                break;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            rx_data = 8'($urandom);
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_report(input logic [7:0] r [8], input int maxgap);
        for (int i = 0; i < 8; i++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send_byte(r[i]);
        end
    endtask

    // Called right after the 8th byte: steps past EVAL and checks the update.
    task automatic expect_update(input string tag, input logic [7:0] k, input logic f,
                                 input logic stb, input logic err);
        rx_valid = 1'b0;
        chk({tag, "_eval_ready"}, rx_ready, 8'h00);
        @(posedge Clk);
        #1;
        chk({tag, "_key"}, keycode,    k);
        chk({tag, "_fire"}, fire,      f);
        chk({tag, "_stb"}, report_stb, stb);
        chk({tag, "_err"}, err_stb,    err);
        idle(2);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 8'h00;
            1: pick = 8'h04;
            2: pick = 8'h50;
            3: pick = 8'h07;
            4: pick = 8'h4F;
            5: pick = 8'h2C;
            6: pick = 8'h01;
            default: pick = 8'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #3 Reset_n = 1'b0;
        #1;
        chk("rst_key",   keycode,    8'h00);
        chk("rst_fire",  fire,       8'h00);
        chk("rst_stb",   report_stb, 8'h00);
        chk("rst_err",   err_stb,    8'h00);
        chk("rst_ready", rx_ready,   8'h00);
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // 1: left, rx_valid held high; strobe one cycle after EVAL
        pkt = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t1", 8'h04, 1'b0, 1'b1, 1'b0);
        chk("t1_stb_one_cycle", report_stb, 8'h00);

        // 2: right + fire, then all zero
        pkt = '{8'h00, 8'h00, 8'h4F, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t2a", 8'h07, 1'b1, 1'b1, 1'b0);
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t2b", 8'h00, 1'b0, 1'b1, 1'b0);

        // 3: both directions, then rollover holds outputs
        pkt = '{8'h00, 8'h00, 8'h50, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t3a", 8'h00, 1'b0, 1'b1, 1'b0);
        pkt = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_report(pkt, 0);
        expect_update("t3b", 8'h00, 1'b0, 1'b0, 1'b1);
        pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C, 8'h07};
        send_report(pkt, 0);
        expect_update("t3c", 8'h07, 1'b1, 1'b1, 1'b0);
        pkt = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_report(pkt, 0);
        expect_update("t3d", 8'h07, 1'b1, 1'b0, 1'b1);

        // 4: three bytes then stall until timeout, then a clean report
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h07);
        rx_valid = 1'b0;
        repeat (T - 1) @(posedge Clk);
        #1;
        chk("t4_err_early", err_stb, 8'h00);
        @(posedge Clk);
        #1;
        chk("t4_err", err_stb, 8'h01);
        chk("t4_key_hold", keycode, 8'h07);
        idle(2);
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t4a", 8'h00, 1'b0, 1'b1, 1'b0);
        pkt = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_report(pkt, 0);
        expect_update("t4b", 8'h07, 1'b0, 1'b1, 1'b0);

        // 5: reset after byte 5 with keycode 07 latched
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        #2 Reset_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("t5_key_rst",   keycode,  8'h00);
        chk("t5_ready_rst", rx_ready, 8'h00);
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        pkt = '{8'h00, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h2C, 8'h00};
        send_report(pkt, 0);
        expect_update("t5", 8'h04, 1'b1, 1'b1, 1'b0);

        // 6: 100 reports with random gaps below timeout, back-to-back allowed
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 8; i++) pkt[i] = (i < 2) ? 8'($urandom) : pick();
            if (r % 10 == 9) for (int i = 2; i < 8; i++) pkt[i] = 8'h01;
            send_report(pkt, 5);
            if ($urandom_range(0, 1) == 1) rx_valid = 1'b0;
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
